// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bus between the ID/EX/MEM datapath and the stall/flush sequencer.
interface pipeline_hazard_controller_if #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CNT      = 16
);
  logic                   i_valid_id;
  logic [NB_REG_ADDR-1:0] i_rs_id;
  logic [NB_REG_ADDR-1:0] i_rt_id;
  logic                   i_uses_rt_id;
  logic                   i_mem_read_ex;
  logic [NB_REG_ADDR-1:0] i_rd_ex;
  logic                   i_branch_taken;
  logic                   i_mem_busy;
  logic                   o_stall_pc;
  logic                   o_stall_if_id;
  logic                   o_bubble_ex;
  logic                   o_flush_if_id;
  logic                   o_stall_all;
  logic [1:0]             o_state;
  logic [NB_CNT-1:0]      o_stall_count;

  // datapath side: reports pipeline status, receives hold/bubble/flush
  modport master (
    output i_valid_id, i_rs_id, i_rt_id, i_uses_rt_id, i_mem_read_ex, i_rd_ex,
           i_branch_taken, i_mem_busy,
    input  o_stall_pc, o_stall_if_id, o_bubble_ex, o_flush_if_id, o_stall_all,
           o_state, o_stall_count
  );

  // sequencer side
  modport slave (
    input  i_valid_id, i_rs_id, i_rt_id, i_uses_rt_id, i_mem_read_ex, i_rd_ex,
           i_branch_taken, i_mem_busy,
    output o_stall_pc, o_stall_if_id, o_bubble_ex, o_flush_if_id, o_stall_all,
           o_state, o_stall_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use stall, data-memory
// wait freeze and taken-branch IF/ID flush, plus a saturating stall counter.
module pipeline_hazard_controller #(
  parameter int NB_REG_ADDR  = 5,
  parameter int N_FLUSH      = 1,
  parameter int NB_FLUSH_CNT = 3,
  parameter int NB_CNT       = 16
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  pipeline_hazard_controller_if.slave  hz
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [NB_FLUSH_CNT-1:0] flush_cnt_q, flush_cnt_d;
  logic [NB_CNT-1:0]       stall_count_q, stall_count_d;

  logic load_use;
  logic stall_pc, stall_if_id, bubble_ex, flush_if_id, stall_all;

  // forwarding cannot cover a load whose result is needed by the very next instruction
  always_comb begin
    load_use = hz.i_valid_id & hz.i_mem_read_ex & (hz.i_rd_ex != '0)
             & ((hz.i_rs_id == hz.i_rd_ex) | (hz.i_uses_rt_id & (hz.i_rt_id == hz.i_rd_ex)));
  end

  // state, flush counter and stall counter registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // next state; MEM_WAIT with memory ready behaves exactly like RUN because ID was frozen
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (hz.i_mem_busy) begin
          state_d = MEM_WAIT;
        end else if (hz.i_branch_taken && (N_FLUSH > 1)) begin
          state_d     = FLUSH;
          flush_cnt_d = NB_FLUSH_CNT'(N_FLUSH - 1);
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        // a memory stall pauses the flush sequence without consuming a flush cycle
        if (!hz.i_mem_busy) begin
          if (flush_cnt_q == NB_FLUSH_CNT'(1)) state_d = RUN;
          else                                 flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // pipeline controls; memory freeze always wins and excludes every other control
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    stall_all   = 1'b0;
    if (!i_reset) begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (hz.i_mem_busy)          stall_all   = 1'b1;
          else if (hz.i_branch_taken) flush_if_id = 1'b1;
          else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
          end
        end
        FLUSH: begin
          // ID holds wrong-path code here, so branch and load-use are ignored
          if (hz.i_mem_busy) stall_all   = 1'b1;
          else               flush_if_id = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // saturating stall-cycle counter
  always_comb begin
    stall_count_d = stall_count_q;
    if ((stall_pc | stall_all) && (stall_count_q != {NB_CNT{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  assign hz.o_stall_pc    = stall_pc;
  assign hz.o_stall_if_id = stall_if_id;
  assign hz.o_bubble_ex   = bubble_ex;
  assign hz.o_flush_if_id = flush_if_id;
  assign hz.o_stall_all   = stall_all;
  assign hz.o_state       = state_q;
  assign hz.o_stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: u0 uses N_FLUSH=1/NB_CNT=16, u1 uses N_FLUSH=3/NB_CNT=4.
// Inputs change at negedge; outputs are sampled 1ns later.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int checks = 0;
  int errors = 0;

  pipeline_hazard_controller_if #(.NB_REG_ADDR(5), .NB_CNT(16)) hz0 ();
  pipeline_hazard_controller_if #(.NB_REG_ADDR(5), .NB_CNT(4))  hz1 ();

  pipeline_hazard_controller #(.NB_REG_ADDR(5), .N_FLUSH(1), .NB_FLUSH_CNT(3), .NB_CNT(16)) u0 (
    .i_clock(clk), .i_reset(rst0), .hz(hz0));
  pipeline_hazard_controller #(.NB_REG_ADDR(5), .N_FLUSH(3), .NB_FLUSH_CNT(3), .NB_CNT(4)) u1 (
    .i_clock(clk), .i_reset(rst1), .hz(hz1));

  // {stall_pc, stall_if_id, bubble_ex, flush_if_id, stall_all}
  function automatic logic [4:0] ctl0();
    return {hz0.o_stall_pc, hz0.o_stall_if_id, hz0.o_bubble_ex, hz0.o_flush_if_id, hz0.o_stall_all};
  endfunction
  function automatic logic [4:0] ctl1();
    return {hz1.o_stall_pc, hz1.o_stall_if_id, hz1.o_bubble_ex, hz1.o_flush_if_id, hz1.o_stall_all};
  endfunction

  task automatic idle0();
    hz0.i_valid_id = 0; hz0.i_rs_id = 0; hz0.i_rt_id = 0; hz0.i_uses_rt_id = 0;
    hz0.i_mem_read_ex = 0; hz0.i_rd_ex = 0; hz0.i_branch_taken = 0; hz0.i_mem_busy = 0;
  endtask
  task automatic idle1();
    hz1.i_valid_id = 0; hz1.i_rs_id = 0; hz1.i_rt_id = 0; hz1.i_uses_rt_id = 0;
    hz1.i_mem_read_ex = 0; hz1.i_rd_ex = 0; hz1.i_branch_taken = 0; hz1.i_mem_busy = 0;
  endtask

  task automatic test_reset();
    rst0 = 1; rst1 = 1; idle0(); idle1();
    hz0.i_mem_busy = 1; hz1.i_branch_taken = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (ctl0() !== 5'b0) begin errors++; $display("FAIL reset_ctl0 got %b want %b", ctl0(), 5'b0); end
    checks++; if (ctl1() !== 5'b0) begin errors++; $display("FAIL reset_ctl1 got %b want %b", ctl1(), 5'b0); end
    checks++; if (hz0.o_state !== 2'd0) begin errors++; $display("FAIL reset_state0 got %0d want 0", hz0.o_state); end
    checks++; if (hz0.o_stall_count !== 16'd0) begin errors++; $display("FAIL reset_count0 got %0d want 0", hz0.o_stall_count); end
    checks++; if (hz1.o_stall_count !== 4'd0) begin errors++; $display("FAIL reset_count1 got %0d want 0", hz1.o_stall_count); end
    rst0 = 0; rst1 = 0; idle0(); idle1();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    hz0.i_valid_id = 1; hz0.i_mem_read_ex = 1; hz0.i_rd_ex = 5; hz0.i_rs_id = 5; #1;
    checks++; if (ctl0() !== 5'b11100) begin errors++; $display("FAIL load_use_stall got %b want %b", ctl0(), 5'b11100); end
    @(negedge clk); idle0(); #1;
    checks++; if (ctl0() !== 5'b0) begin errors++; $display("FAIL load_use_release got %b want %b", ctl0(), 5'b0); end
    checks++; if (hz0.o_stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count got %0d want 1", hz0.o_stall_count); end
  endtask

  task automatic test_load_use_neg();
    @(negedge clk);
    hz0.i_valid_id = 1; hz0.i_mem_read_ex = 1; hz0.i_rd_ex = 0; hz0.i_rs_id = 0; #1;
    checks++; if (ctl0() !== 5'b0) begin errors++; $display("FAIL lu_r0 got %b want %b", ctl0(), 5'b0); end
    @(negedge clk);
    hz0.i_rd_ex = 7; hz0.i_rs_id = 3; hz0.i_rt_id = 7; hz0.i_uses_rt_id = 0; #1;
    checks++; if (ctl0() !== 5'b0) begin errors++; $display("FAIL lu_rt_unused got %b want %b", ctl0(), 5'b0); end
    @(negedge clk);
    hz0.i_uses_rt_id = 1; #1;
    checks++; if (ctl0() !== 5'b11100) begin errors++; $display("FAIL lu_rt_used got %b want %b", ctl0(), 5'b11100); end
    @(negedge clk); idle0(); #1;
    checks++; if (hz0.o_stall_count !== 16'd2) begin errors++; $display("FAIL lu_neg_count got %0d want 2", hz0.o_stall_count); end
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_state [0:2];
    exp_state[0] = 2'd0; exp_state[1] = 2'd1; exp_state[2] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); hz0.i_mem_busy = 1; #1;
      checks++; if (ctl0() !== 5'b00001) begin errors++; $display("FAIL mem_wait_ctl[%0d] got %b want %b", i, ctl0(), 5'b00001); end
      checks++; if (hz0.o_state !== exp_state[i]) begin errors++; $display("FAIL mem_wait_state[%0d] got %0d want %0d", i, hz0.o_state, exp_state[i]); end
    end
    @(negedge clk); hz0.i_mem_busy = 0; #1;
    checks++; if (ctl0() !== 5'b0) begin errors++; $display("FAIL mem_wait_exit_ctl got %b want %b", ctl0(), 5'b0); end
    @(negedge clk); #1;
    checks++; if (hz0.o_state !== 2'd0) begin errors++; $display("FAIL mem_wait_back_run got %0d want 0", hz0.o_state); end
    checks++; if (hz0.o_stall_count !== 16'd5) begin errors++; $display("FAIL mem_wait_count got %0d want 5", hz0.o_stall_count); end
  endtask

  task automatic test_branch_single();
    @(negedge clk); hz0.i_branch_taken = 1; #1;
    checks++; if (ctl0() !== 5'b00010) begin errors++; $display("FAIL br1_flush got %b want %b", ctl0(), 5'b00010); end
    @(negedge clk); hz0.i_branch_taken = 0; #1;
    checks++; if (ctl0() !== 5'b0) begin errors++; $display("FAIL br1_one_cycle got %b want %b", ctl0(), 5'b0); end
    checks++; if (hz0.o_state !== 2'd0) begin errors++; $display("FAIL br1_state got %0d want 0", hz0.o_state); end
    @(negedge clk); hz0.i_mem_busy = 1; hz0.i_branch_taken = 1; #1;
    checks++; if (ctl0() !== 5'b00001) begin errors++; $display("FAIL br1_busy got %b want %b", ctl0(), 5'b00001); end
    @(negedge clk); hz0.i_mem_busy = 0; #1;
    checks++; if (ctl0() !== 5'b00010) begin errors++; $display("FAIL br1_after_wait got %b want %b", ctl0(), 5'b00010); end
    @(negedge clk); idle0(); #1;
    checks++; if (hz0.o_state !== 2'd0) begin errors++; $display("FAIL br1_end_state got %0d want 0", hz0.o_state); end
    checks++; if (hz0.o_stall_count !== 16'd6) begin errors++; $display("FAIL br1_count got %0d want 6", hz0.o_stall_count); end
  endtask

  task automatic test_flush_pause();
    // per cycle: busy input, expected ctl, expected state
    logic       busy [0:5];
    logic [4:0] ec   [0:5];
    logic [1:0] es   [0:5];
    busy[0] = 0; ec[0] = 5'b00010; es[0] = 2'd0;
    busy[1] = 0; ec[1] = 5'b00010; es[1] = 2'd2;
    busy[2] = 1; ec[2] = 5'b00001; es[2] = 2'd2;
    busy[3] = 1; ec[3] = 5'b00001; es[3] = 2'd2;
    busy[4] = 0; ec[4] = 5'b00010; es[4] = 2'd2;
    busy[5] = 0; ec[5] = 5'b00000; es[5] = 2'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hz1.i_branch_taken = (i == 0); hz1.i_mem_busy = busy[i]; #1;
      checks++; if (ctl1() !== ec[i]) begin errors++; $display("FAIL flush3_ctl[%0d] got %b want %b", i, ctl1(), ec[i]); end
      checks++; if (hz1.o_state !== es[i]) begin errors++; $display("FAIL flush3_state[%0d] got %0d want %0d", i, hz1.o_state, es[i]); end
    end
    checks++; if (hz1.o_stall_count !== 4'd2) begin errors++; $display("FAIL flush3_count got %0d want 2", hz1.o_stall_count); end
    idle1();
  endtask

  task automatic test_combined();
    logic [4:0] ec [0:4];
    logic [1:0] es [0:4];
    ec[0] = 5'b00001; es[0] = 2'd0;
    ec[1] = 5'b00010; es[1] = 2'd1;
    ec[2] = 5'b00010; es[2] = 2'd2;
    ec[3] = 5'b00010; es[3] = 2'd2;
    ec[4] = 5'b00000; es[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        hz1.i_branch_taken = 1; hz1.i_valid_id = 1; hz1.i_mem_read_ex = 1;
        hz1.i_rd_ex = 4; hz1.i_rs_id = 4; hz1.i_mem_busy = (i == 0);
      end else idle1();
      #1;
      checks++; if (ctl1() !== ec[i]) begin errors++; $display("FAIL combo_ctl[%0d] got %b want %b", i, ctl1(), ec[i]); end
      checks++; if (hz1.o_state !== es[i]) begin errors++; $display("FAIL combo_state[%0d] got %0d want %0d", i, hz1.o_state, es[i]); end
    end
    checks++; if (hz1.o_stall_count !== 4'd3) begin errors++; $display("FAIL combo_count got %0d want 3", hz1.o_stall_count); end
  endtask

  task automatic test_reset_mid();
    // reset while in MEM_WAIT
    @(negedge clk); hz1.i_mem_busy = 1;
    @(negedge clk); rst1 = 1; #1;
    checks++; if (hz1.o_state !== 2'd1) begin errors++; $display("FAIL rst_mw_pre_state got %0d want 1", hz1.o_state); end
    checks++; if (ctl1() !== 5'b0) begin errors++; $display("FAIL rst_mw_ctl got %b want %b", ctl1(), 5'b0); end
    @(negedge clk); rst1 = 0; idle1(); #1;
    checks++; if (hz1.o_state !== 2'd0) begin errors++; $display("FAIL rst_mw_state got %0d want 0", hz1.o_state); end
    checks++; if (hz1.o_stall_count !== 4'd0) begin errors++; $display("FAIL rst_mw_count got %0d want 0", hz1.o_stall_count); end
    // reset while in FLUSH, after a paused cycle bumped the counter
    @(negedge clk); hz1.i_branch_taken = 1;
    @(negedge clk); hz1.i_branch_taken = 0; hz1.i_mem_busy = 1;
    @(negedge clk); rst1 = 1; #1;
    checks++; if (hz1.o_state !== 2'd2) begin errors++; $display("FAIL rst_fl_pre_state got %0d want 2", hz1.o_state); end
    checks++; if (ctl1() !== 5'b0) begin errors++; $display("FAIL rst_fl_ctl got %b want %b", ctl1(), 5'b0); end
    @(negedge clk); rst1 = 0; idle1(); #1;
    checks++; if (hz1.o_state !== 2'd0) begin errors++; $display("FAIL rst_fl_state got %0d want 0", hz1.o_state); end
    checks++; if (hz1.o_stall_count !== 4'd0) begin errors++; $display("FAIL rst_fl_count got %0d want 0", hz1.o_stall_count); end
    checks++; if (ctl1() !== 5'b0) begin errors++; $display("FAIL rst_fl_noflush got %b want %b", ctl1(), 5'b0); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); hz1.i_mem_busy = 1; #1;
      if (i == 15) begin
        checks++; if (hz1.o_stall_count !== 4'd15) begin errors++; $display("FAIL sat_reach got %0d want 15", hz1.o_stall_count); end
      end
    end
    @(negedge clk); idle1(); #1;
    checks++; if (hz1.o_stall_count !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", hz1.o_stall_count); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_use_neg();
    test_mem_wait();
    test_branch_single();
    test_flush_pause();
    test_combined();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
